// File: rtl/ddr_deser8_if.sv
// Byte-side and DDR-pair signals of the 8-bit DDR deserializer.
// out_valid/out_ready: a byte moves when both are high on a rising edge; out_data holds while out_valid && !out_ready.
interface ddr_deser8_if;
   logic       rise_bit;
   logic       fall_bit;
   logic       en;
   logic       align_req;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       locked;
   logic       overflow;

   modport master (
      output rise_bit, fall_bit, en, align_req, out_ready,
      input  out_data, out_valid, locked, overflow
   );

   modport slave (
      input  rise_bit, fall_bit, en, align_req, out_ready,
      output out_data, out_valid, locked, overflow
   );
endinterface

// File: rtl/ddr_deser8.sv
// DDR bit-pair deserializer: hunts for SYNC_WORD at either bit phase, verifies it, then emits bytes into a 4-deep FWFT FIFO.
// dbg_state_o encoding: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.
module ddr_deser8 #(
   parameter logic [7:0] SYNC_WORD  = 8'hA5,
   parameter int         LOCK_COUNT = 3
) (
   input  logic         clk,
   input  logic         rst,
   ddr_deser8_if.slave  bus,
   output logic [1:0]   dbg_state_o,
   output logic         dbg_offset_o,
   output logic [9:0]   dbg_hist_o
);
   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

   state_t      state_q, state_d;
   logic [9:0]  hist_q, hist_d;
   logic        offset_q, offset_d;
   logic [1:0]  pc_q, pc_d;
   logic [2:0]  match_q, match_d;
   logic [7:0]  cand0, cand1, word;
   logic        push;

   logic [7:0]  mem_q [4];
   logic [1:0]  rd_q, wr_q;
   logic [2:0]  cnt_q;
   logic        ovf_q;
   logic        pop, wr_ok;

   // Candidates are taken from the post-shift history so a match is seen on the pair that completes it.
   assign hist_d = bus.en ? {hist_q[7:0], bus.rise_bit, bus.fall_bit} : hist_q;
   assign cand0  = hist_d[7:0];
   assign cand1  = hist_d[8:1];
   assign word   = offset_q ? cand1 : cand0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         hist_q   <= '0;
         offset_q <= 1'b0;
         pc_q     <= '0;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         hist_q   <= hist_d;
         offset_q <= offset_d;
         pc_q     <= pc_d;
         match_q  <= match_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      pc_d     = pc_q;
      match_d  = match_q;
      push     = 1'b0;
      if (bus.align_req) begin
         state_d = HUNT;
      end else if (bus.en) begin
         case (state_q)
            HUNT: begin
               if (cand0 == SYNC_WORD || cand1 == SYNC_WORD) begin
                  offset_d = (cand0 != SYNC_WORD);
                  pc_d     = 2'd0;
                  match_d  = 3'd1;
                  state_d  = (LOCK_N == 3'd1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               pc_d = pc_q + 2'd1;
               if (pc_q == 2'd3) begin
                  if (word == SYNC_WORD) begin
                     match_d = match_q + 3'd1;
                     if (match_q + 3'd1 == LOCK_N) state_d = LOCKED;
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               pc_d = pc_q + 2'd1;
               push = (pc_q == 2'd3);
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign pop   = (cnt_q != 3'd0) && bus.out_ready;
   assign wr_ok = push && ((cnt_q != 3'd4) || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (wr_ok) wr_q <= wr_q + 2'd1;
         if (pop)   rd_q <= rd_q + 2'd1;
         cnt_q <= cnt_q + {2'b00, wr_ok} - {2'b00, pop};
         if (bus.align_req)       ovf_q <= 1'b0;
         else if (push && !wr_ok) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_q] <= word;
   end

   assign bus.out_valid = (cnt_q != 3'd0);
   assign bus.out_data  = bus.out_valid ? mem_q[rd_q] : 8'h00;
   assign bus.locked    = (state_q == LOCKED);
   assign bus.overflow  = ovf_q;
   assign dbg_state_o   = state_q;
   assign dbg_offset_o  = offset_q;
   assign dbg_hist_o    = hist_q;
endmodule

// File: tb/tb_ddr_deser8.sv
// Randomized and directed bench for ddr_deser8 against a bit-stream reference model with a byte scoreboard.
module tb_ddr_deser8;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         LOCK = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   logic       dbg_offset;
   logic [9:0] dbg_hist;

   ddr_deser8_if bus ();

   ddr_deser8 #(.SYNC_WORD(SYNC), .LOCK_COUNT(LOCK)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .dbg_state_o  (dbg_state),
      .dbg_offset_o (dbg_offset),
      .dbg_hist_o   (dbg_hist)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   // Reference model: whole received bit stream plus the index where the last accepted word ended.
   bit         bits[$];
   int         bnd;
   int         m_mode;      // 0 hunt, 1 verify, 2 locked
   bit         m_offset;
   int         m_matches;
   int         m_cnt;
   bit         m_overflow;
   logic [7:0] exp_q[$];
   bit         tx_q[$];

   task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] word_at(int e);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[7-i] = bits[e-8+i];
      return w;
   endfunction

   function automatic logic [9:0] last10();
      logic [9:0] h;
      for (int i = 0; i < 10; i++) h[i] = bits[bits.size()-1-i];
      return h;
   endfunction

   task automatic model_reset();
      bits.delete();
      repeat (10) bits.push_back(1'b0);
      bnd = 0; m_mode = 0; m_offset = 1'b0; m_matches = 0;
      m_cnt = 0; m_overflow = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step(bit r, bit f, bit e, bit a, bit rs, bit rdy);
      bit         pop_m, push_m, acc;
      int         n;
      logic [7:0] w;
      w = 8'h00; push_m = 1'b0; acc = 1'b0;
      if (rs) begin
         model_reset();
         return;
      end
      pop_m = (m_cnt != 0) && rdy;
      if (e) begin
         bits.push_back(r);
         bits.push_back(f);
      end
      n = bits.size();
      if (a) begin
         m_mode = 0;
         m_overflow = 1'b0;
      end else if (e) begin
         if (m_mode == 0) begin
            if (word_at(n) == SYNC) begin
               bnd = n; m_offset = 1'b0; m_matches = 1; m_mode = (LOCK == 1) ? 2 : 1;
            end else if (word_at(n-1) == SYNC) begin
               bnd = n - 1; m_offset = 1'b1; m_matches = 1; m_mode = (LOCK == 1) ? 2 : 1;
            end
         end else if (n >= bnd + 8) begin
            w = word_at(bnd + 8);
            bnd += 8;
            if (m_mode == 2) push_m = 1'b1;
            else if (w == SYNC) begin
               m_matches++;
               if (m_matches == LOCK) m_mode = 2;
            end else m_mode = 0;
         end
      end
      if (push_m) begin
         if (m_cnt < 4 || pop_m) begin
            exp_q.push_back(w);
            acc = 1'b1;
         end else m_overflow = 1'b1;
      end
      m_cnt = m_cnt + int'(acc) - int'(pop_m);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid", 10'(bus.out_valid), 10'(m_cnt != 0));
         chk("locked", 10'(bus.locked), 10'(m_mode == 2));
         chk("state", 10'(dbg_state), 10'(m_mode));
         chk("overflow", 10'(bus.overflow), 10'(m_overflow));
         chk("hist", dbg_hist, last10());
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_empty: got %0h expected no byte at %0t", bus.out_data, $time);
            end else begin
               chk("data", 10'(bus.out_data), 10'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic drive(bit r, bit f, bit e, bit a, bit rs, bit rdy);
      bus.rise_bit = r; bus.fall_bit = f; bus.en = e;
      bus.align_req = a; rst = rs; bus.out_ready = rdy;
      @(negedge clk); #1;
      model_step(r, f, e, a, rs, rdy);
      @(posedge clk); #1;
   endtask

   function automatic bit rnd_pct(int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic add_byte(logic [7:0] b);
      for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
   endtask

   task automatic pump(int gap_pct, int rdy_pct);
      while (tx_q.size() >= 2) begin
         bit r, f;
         if (rnd_pct(gap_pct))
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, rnd_pct(rdy_pct));
         r = tx_q.pop_front();
         f = tx_q.pop_front();
         drive(r, f, 1'b1, 1'b0, 1'b0, rnd_pct(rdy_pct));
      end
   endtask

   task automatic idle(int n, bit rdy);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic do_reset(string nm);
      tx_q.delete();
      drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 1'b1, 1'b1);
      chk({nm, "_valid"}, 10'(bus.out_valid), 10'd0);
      chk({nm, "_data"}, 10'(bus.out_data), 10'd0);
      chk({nm, "_locked"}, 10'(bus.locked), 10'd0);
      chk({nm, "_ovf"}, 10'(bus.overflow), 10'd0);
      chk({nm, "_hist"}, dbg_hist, 10'd0);
   endtask

   task automatic lock_a5();
      repeat (3) add_byte(SYNC);
      pump(0, 100);
   endtask

   initial begin
      bus.rise_bit = 1'b0; bus.fall_bit = 1'b0; bus.en = 1'b0;
      bus.align_req = 1'b0; bus.out_ready = 1'b0; rst = 1'b1;
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      mon_en = 1'b1;
      do_reset("por");

      // Offset-0 lock, training words stay out of the FIFO.
      repeat (2) add_byte(SYNC);
      pump(0, 100);
      chk("lock_early", 10'(bus.locked), 10'd0);
      add_byte(SYNC);
      pump(0, 100);
      chk("lock_even", 10'(bus.locked), 10'd1);
      chk("train_hidden", 10'(bus.out_valid), 10'd0);
      add_byte(8'h3C);
      pump(0, 100);
      chk("lat_valid", 10'(bus.out_valid), 10'd1);
      chk("lat_data", 10'(bus.out_data), 10'h3C);
      idle(3, 1'b1);

      // Offset-1 lock behind a stray bit.
      do_reset("rst_odd");
      tx_q.push_back(1'b1);
      repeat (3) add_byte(SYNC);
      add_byte(8'h5A);
      tx_q.push_back(1'b0);
      pump(0, 0);
      chk("odd_offset", 10'(dbg_offset), 10'd1);
      chk("odd_locked", 10'(bus.locked), 10'd1);
      chk("odd_data", 10'(bus.out_data), 10'h5A);
      idle(3, 1'b1);

      // Verify failure then clean relock.
      do_reset("rst_vfail");
      add_byte(SYNC); add_byte(SYNC); add_byte(8'h00);
      pump(0, 100);
      chk("vfail_state", 10'(dbg_state), 10'd0);
      chk("vfail_locked", 10'(bus.locked), 10'd0);
      lock_a5();
      chk("relock", 10'(bus.locked), 10'd1);

      // Backpressure, overflow, and push coincident with the first pop.
      for (int b = 1; b <= 5; b++) add_byte(8'(b));
      pump(0, 0);
      chk("bp_ovf", 10'(bus.overflow), 10'd1);
      chk("bp_head", 10'(bus.out_data), 10'h01);
      add_byte(8'h06);
      while (tx_q.size() > 2) begin
         bit r, f;
         r = tx_q.pop_front(); f = tx_q.pop_front();
         drive(r, f, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      drive(tx_q[0], tx_q[1], 1'b1, 1'b0, 1'b0, 1'b1);
      tx_q.delete();
      chk("bp_full_after", 10'(bus.out_data), 10'h02);
      idle(6, 1'b1);

      // align_req on a word-complete edge.
      add_byte(8'h21); add_byte(8'h22);
      pump(0, 0);
      add_byte(8'h77);
      while (tx_q.size() > 2) begin
         bit r, f;
         r = tx_q.pop_front(); f = tx_q.pop_front();
         drive(r, f, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      drive(tx_q[0], tx_q[1], 1'b1, 1'b1, 1'b0, 1'b0);
      tx_q.delete();
      chk("align_locked", 10'(bus.locked), 10'd0);
      chk("align_state", 10'(dbg_state), 10'd0);
      chk("align_ovf", 10'(bus.overflow), 10'd0);
      chk("align_head", 10'(bus.out_data), 10'h21);
      idle(4, 1'b1);

      // Reset mid-word with two bytes stored.
      do_reset("rst_pre");
      lock_a5();
      add_byte(8'h31); add_byte(8'h32); add_byte(8'h33);
      while (tx_q.size() > 4) begin
         bit r, f;
         r = tx_q.pop_front(); f = tx_q.pop_front();
         drive(r, f, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("pre_rst_valid", 10'(bus.out_valid), 10'd1);
      do_reset("rst_mid");

      // en gaps between pairs.
      lock_a5();
      add_byte(8'h41); add_byte(8'h42); add_byte(8'h43);
      pump(50, 100);
      idle(4, 1'b1);

      // Random episodes: stray bits, noisy training, random payload, random gaps and backpressure.
      for (int ep = 0; ep < 30; ep++) begin
         if ($urandom_range(3) == 0) do_reset("rst_rand");
         else drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         repeat ($urandom_range(3)) tx_q.push_back(1'($urandom_range(1)));
         repeat (3) add_byte(($urandom_range(7) == 0) ? 8'($urandom) : SYNC);
         repeat ($urandom_range(10, 4)) add_byte(8'($urandom));
         if ($urandom_range(3) == 0) add_byte(SYNC);
         pump(30, 60);
      end
      idle(10, 1'b1);
      chk("drained", 10'(exp_q.size()), 10'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ddr_deser8.md
DDR_DESER8 -- requirements
Module: ddr_deser8

Interface
REQ-001 Parameter: SYNC_WORD, default 8'hA5, the training word that marks byte boundaries.
REQ-002 Parameter: LOCK_COUNT, default 3, range 1..7, the number of consecutive aligned SYNC_WORDs required for lock.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 rise_bit  in  1  bit captured on the clk rising edge by the upstream DDR capture stage; earlier bit in time.
REQ-006 fall_bit  in  1  bit captured on the clk falling edge by the upstream DDR capture stage; later bit in time.
REQ-007 en  in  1  rise_bit/fall_bit pair valid this cycle.
REQ-008 align_req  in  1  single-cycle request to drop alignment and re-hunt.
REQ-009 out_ready  in  1  consumer accepts out_data.
REQ-010 out_data  out  8  deserialized byte, MSB first in time.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 locked  out  1  high while in LOCKED.
REQ-013 overflow  out  1  sticky; a byte was dropped.

Function
REQ-014 On each en cycle, hist[9:0] SHALL update as hist <= {hist[7:0], rise_bit, fall_bit}; hist SHALL hold when en=0.
REQ-015 Candidate words use the post-shift value hn: cand0 = hn[7:0] and cand1 = hn[8:1].
REQ-016 The FSM SHALL have three states: HUNT, VERIFY and LOCKED. It also keeps a 1-bit offset, a 2-bit pair counter pc, and a 3-bit match_cnt.
REQ-017 HUNT, on an en cycle where cand0==SYNC_WORD:
  - offset <= 0, pc <= 0, match_cnt <= 1.
  - Next state is LOCKED if LOCK_COUNT==1, otherwise VERIFY.
REQ-018 HUNT, on an en cycle where cand0!=SYNC_WORD and cand1==SYNC_WORD: same action as REQ-017 but with offset <= 1. When both candidates match, cand0 wins.
REQ-019 VERIFY and LOCKED: pc SHALL increment on each en cycle. A word-complete event occurs on the en cycle with pc==3, and the word is cand[offset].
REQ-020 VERIFY, on word-complete:
  - If the word equals SYNC_WORD, match_cnt increments, and the state goes to LOCKED when match_cnt+1==LOCK_COUNT.
  - Otherwise the state goes to HUNT.
  - VERIFY words are never pushed to the FIFO.
REQ-021 LOCKED: every word-complete SHALL push the word into the output FIFO, SYNC_WORD included. LOCKED is left only on align_req or rst.
REQ-022 align_req=1 SHALL force the state to HUNT next cycle and clear overflow.
  - It takes priority over any match or word-complete in the same cycle.
  - hist still shifts if en=1.
  - No push occurs that cycle.
  - The FIFO is not flushed.
REQ-023 Output FIFO is 4 entries, first-word-fall-through. out_valid = (count!=0), and out_data = the head entry.
REQ-024 A pop occurs when out_valid and out_ready are both 1. Latency: a pushed byte SHALL be visible on out_data the cycle after the push edge when the FIFO was empty.
REQ-025 FIFO full-boundary behaviour:
  - A push with count==4 and no pop in the same cycle SHALL drop the byte and set overflow.
  - A push with count==4 and a simultaneous pop SHALL succeed, and count stays 4.
REQ-026 A simultaneous push and pop with count==0 is impossible: out_valid is 0, so no pop occurs. The push SHALL complete normally.
REQ-027 locked = (state==LOCKED), registered.

Reset
REQ-028 On rst, the following SHALL be cleared:
  - hist=0, pc=0, offset=0, match_cnt=0.
  - state=HUNT, FIFO count=0.
  - out_valid=0, out_data=8'h00, locked=0, overflow=0.
REQ-029 rst SHALL take priority over en and align_req. rst asserted mid-word or mid-FIFO SHALL discard all partial and stored data.

Verification
REQ-030 Offset-0 lock: after rst, drive en=1 with pairs forming A5,A5,A5,3C aligned at even bits.
  - Required: locked rises after the third A5.
  - Required: A5 is not output during training.
  - Required: 3C appears on out_data with out_valid the cycle after its 4th pair.
REQ-031 Offset-1 lock: prefix one stray bit before A5 x3 then 5A.
  - Required: offset=1 and locked=1.
  - Required: out_data=8'h5A.
REQ-032 Verify failure: A5, A5, 00.
  - Required: return to HUNT with locked=0.
  - Required: a subsequent clean A5 x3 locks.
REQ-033 Backpressure: while locked, hold out_ready=0 and stream 5 bytes 01..05.
  - Required: FIFO holds 01..04 and overflow=1.
  - Required: raising out_ready drains 01,02,03,04 in order.
  - Required: a byte completing on the same cycle as the first pop is accepted.
REQ-034 align_req coincident with word-complete in LOCKED.
  - Required: no push, state=HUNT next cycle, locked=0, overflow cleared.
  - Required: FIFO contents are preserved.
REQ-035 rst asserted mid-word with 2 bytes in the FIFO.
  - Required: out_valid=0, locked=0, and all outputs at their reset values next cycle.
REQ-036 en=0 gaps inserted between pairs.
  - Required: hist and pc hold.
  - Required: the byte value and word-complete timing relative to en cycles are unchanged.
